light_lamp_driver: RTL and testbench
====================================

LIGHT_LAMP_DRIVER -- requirements
Module: light_lamp_driver

Interface
REQ-001 SHALL have parameter PED_STEADY, default 20, meaning cycles ped green is lit steady before it starts flashing.
REQ-002 SHALL have parameter FLASH_HALF, default 5, meaning cycles per on or off half-period of any flashing lamp.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port main_light, input, 2 bits: main-road light code from controller (00 red, 01 green, 10 yellow, 11 illegal).
REQ-006 SHALL have port ped_light, input, 2 bits: pedestrian light code (00 red, 01 green, 1x illegal).
REQ-007 SHALL have port fault_clr, input, 1 bit: level request to clear a latched fault.
REQ-008 SHALL have port main_lamp, output, 3 bits: {red, yellow, green} lamp drives, active high.
REQ-009 SHALL have port ped_lamp, output, 2 bits: {red, green} lamp drives, active high.
REQ-010 SHALL have port fault, output, 1 bit: latched safety fault.
REQ-011 SHALL have port fault_code, output, 2 bits: cause of the latched fault (00 none, 01 conflict, 10 illegal code, 11 illegal sequence).

Function
REQ-012 SHALL register main_light and ped_light into sample registers every cycle; all decoding and checks use the samples only.
REQ-013 SHALL keep a registered previous main sample so that main transitions can be detected.
REQ-014 SHALL update lamp outputs one cycle after the sample register: an input change setup before edge N appears on the lamps after edge N+1.
REQ-015 SHALL use states NORMAL and FAULT.
REQ-016 In NORMAL, SHALL decode the main sample one-hot: 00 -> 100, 01 -> 001, 10 -> 010.
REQ-017 In NORMAL, SHALL drive ped_lamp 10 for ped sample 00.
REQ-018 In NORMAL with ped sample 01, SHALL drive ped_lamp 01 steady for the first PED_STEADY cycles.
REQ-019 After those PED_STEADY cycles, SHALL flash the ped green bit, starting with an off phase of FLASH_HALF cycles, then on, alternating, while the ped red bit stays 0.
REQ-020 SHALL clear the ped green dwell counter and flash phase whenever the ped sample is not 01; re-entering green restarts the steady period.
REQ-021 SHALL saturate the dwell counter at PED_STEADY; it SHALL NOT wrap.
REQ-022 SHALL detect fault 01 (conflict) when the main sample is 01 or 10 while the ped sample is 01.
REQ-023 SHALL detect fault 10 (illegal code) when the main sample is 11 or the ped sample is 1x.
REQ-024 SHALL detect fault 11 (illegal sequence) when the main sample goes 01 -> 00 directly, or 00 -> 10.
REQ-025 When several faults are detected in the same cycle, SHALL record by priority 01 > 10 > 11.
REQ-026 On any detection in NORMAL, SHALL go to FAULT, set fault=1 and latch fault_code on the same edge that would have shown the offending lamps; the offending decode SHALL never reach the lamps.
REQ-027 In FAULT, SHALL drive main_lamp red bit flashing at FLASH_HALF, starting on, with yellow and green 0.
REQ-028 In FAULT, SHALL drive ped_lamp 10 steady.
REQ-029 In FAULT, SHALL ignore further detections; fault_code holds its first value.
REQ-030 SHALL exit FAULT only when fault_clr=1 with main sample 00 and ped sample 00 in the same cycle; on that edge fault=0, fault_code=00, state NORMAL, and lamps decode normally from the next edge.
REQ-031 SHALL ignore fault_clr in NORMAL, and in FAULT while either sample is non-red.
REQ-032 On exit from FAULT, SHALL load the previous-main register with 00 so that no sequence fault arises from pre-fault history.

Reset
REQ-033 While rst_n=0, asynchronously: main_lamp=100, ped_lamp=10, fault=0, fault_code=00, state NORMAL, samples and previous-main=00, counters and flash phase 0.
REQ-034 Reset deassertion mid-operation SHALL resume NORMAL decoding from the next samples, with no residual flash phase or dwell count.

Verification
REQ-035 Reset, then main 00->01->10->00 and ped 00: main_lamp 100->001->010->100, each change 2 edges after the input change; fault=0 throughout.
REQ-036 PED_STEADY=20, FLASH_HALF=5, ped 01 held 40 cycles with main 00: ped_lamp=01 for 20 cycles, then green 0 for 5 cycles, 1 for 5, 0 for 5, 1 for 5; dropping ped to 00 gives ped_lamp=10.
REQ-037 main 01 with ped 01 applied together: fault=1 and fault_code=01; main_lamp red toggles every 5 cycles; ped_lamp=10; main green is never driven.
REQ-038 main 01->00 directly: fault_code=11; fault_clr=1 while main 01 -> no clear; fault_clr=1 with both 00 -> fault=0 next edge, normal decode resumes.
REQ-039 main 11 and ped 10 together in one cycle: fault_code=10 (priority over sequence); subsequent conflict -> fault_code stays 10.
REQ-040 rst_n pulsed low during FAULT and during ped flash: outputs immediately 100/10/0/00; after release, ped 01 restarts a full 20-cycle steady green.

Source files
------------

// File: rtl/light_lamp_driver.sv
// light_lamp_driver: safety lamp driver between a traffic controller and its lamps.
// The controller light codes are sampled every cycle. From those samples the block
// drives one-hot main lamps and pedestrian lamps, with a steady-then-flashing
// pedestrian green. It latches conflict, illegal-code and illegal-sequence faults
// into a red-flash safe state, which it leaves only on an explicit clear.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   main_light[1:0]    main code: 00 red, 01 green, 10 yellow, 11 illegal
//   ped_light[1:0]     ped code: 00 red, 01 green, 1x illegal
//   fault_clr          level request to leave the fault state
//   main_lamp[2:0]     {red, yellow, green} lamp drives
//   ped_lamp[1:0]      {red, green} lamp drives
//   fault              latched safety fault
//   fault_code[1:0]    00 none, 01 conflict, 10 illegal code, 11 illegal sequence
module light_lamp_driver #(
  parameter int unsigned PED_STEADY = 20,
  parameter int unsigned FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] main_light,
  input  logic [1:0] ped_light,
  input  logic       fault_clr,
  output logic [2:0] main_lamp,
  output logic [1:0] ped_lamp,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned DW = (PED_STEADY > 0) ? $clog2(PED_STEADY + 1) : 1;
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  typedef enum logic {NORMAL, FAULT} state_t;

  state_t          state, state_n;
  logic [1:0]      main_s, ped_s, prev_main, prev_main_n;
  logic [DW-1:0]   dwell, dwell_n;
  logic [FW-1:0]   fcnt, fcnt_n, base_cnt, adv_cnt;
  logic            fphase, fphase_n, base_phase, adv_phase;
  logic [2:0]      main_lamp_n;
  logic [1:0]      ped_lamp_n, fault_code_n, det_code;
  logic            fault_n;
  logic            conflict, illegal, seq_bad, ped_flashing, flash_keep, clr_ok;

  // Fault detection from the samples, recorded by priority conflict > illegal > sequence.
  assign conflict = ((main_s == 2'b01) || (main_s == 2'b10)) && (ped_s == 2'b01);
  assign illegal  = (main_s == 2'b11) || ped_s[1];
  assign seq_bad  = ((prev_main == 2'b01) && (main_s == 2'b00)) ||
                    ((prev_main == 2'b00) && (main_s == 2'b10));
  assign det_code = conflict ? 2'b01 : illegal ? 2'b10 : seq_bad ? 2'b11 : 2'b00;

  assign clr_ok       = fault_clr && (main_s == 2'b00) && (ped_s == 2'b00);
  assign ped_flashing = (ped_s == 2'b01) && (dwell == DW'(PED_STEADY));

  // One shared flash timer. It continues while flashing and otherwise starts from
  // (0, phase 0). The current cycle displays base_phase.
  assign flash_keep = (state == FAULT) ? !clr_ok : ((det_code == 2'b00) && ped_flashing);
  assign base_cnt   = flash_keep ? fcnt : '0;
  assign base_phase = flash_keep ? fphase : 1'b0;
  assign adv_cnt    = (base_cnt == FW'(FLASH_HALF - 1)) ? '0 : base_cnt + FW'(1);
  assign adv_phase  = (base_cnt == FW'(FLASH_HALF - 1)) ? ~base_phase : base_phase;

  // Next state and next registered outputs.
  always_comb begin
    state_n      = state;
    prev_main_n  = main_s;
    dwell_n      = '0;
    fcnt_n       = '0;
    fphase_n     = 1'b0;
    main_lamp_n  = 3'b100;
    ped_lamp_n   = 2'b10;
    fault_n      = fault;
    fault_code_n = fault_code;
    unique case (state)
      NORMAL: begin
        if (det_code != 2'b00) begin
          // Enter the safe state on the edge that would have shown the offending decode.
          state_n      = FAULT;
          fault_n      = 1'b1;
          fault_code_n = det_code;
          main_lamp_n  = {~base_phase, 2'b00};
          fcnt_n       = adv_cnt;
          fphase_n     = adv_phase;
        end else begin
          unique case (main_s)
            2'b01:   main_lamp_n = 3'b001;
            2'b10:   main_lamp_n = 3'b010;
            default: main_lamp_n = 3'b100;
          endcase
          if (ped_s == 2'b01) begin
            if (ped_flashing) begin
              dwell_n    = dwell;
              ped_lamp_n = {1'b0, base_phase};
              fcnt_n     = adv_cnt;
              fphase_n   = adv_phase;
            end else begin
              dwell_n    = dwell + DW'(1);
              ped_lamp_n = 2'b01;
            end
          end
        end
      end
      FAULT: begin
        if (clr_ok) begin
          state_n      = NORMAL;
          fault_n      = 1'b0;
          fault_code_n = 2'b00;
          prev_main_n  = 2'b00;
        end else begin
          main_lamp_n = {~base_phase, 2'b00};
          fcnt_n      = adv_cnt;
          fphase_n    = adv_phase;
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  // State, samples and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      main_s     <= 2'b00;
      ped_s      <= 2'b00;
      prev_main  <= 2'b00;
      dwell      <= '0;
      fcnt       <= '0;
      fphase     <= 1'b0;
      main_lamp  <= 3'b100;
      ped_lamp   <= 2'b10;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_n;
      main_s     <= main_light;
      ped_s      <= ped_light;
      prev_main  <= prev_main_n;
      dwell      <= dwell_n;
      fcnt       <= fcnt_n;
      fphase     <= fphase_n;
      main_lamp  <= main_lamp_n;
      ped_lamp   <= ped_lamp_n;
      fault      <= fault_n;
      fault_code <= fault_code_n;
    end
  end

endmodule

// File: tb/tb_light_lamp_driver.sv
// Self-checking bench for light_lamp_driver. Each stimulus step queues the output
// expected two edges later, and that expectation is popped one edge after the step.
module tb_light_lamp_driver;

  typedef struct packed {
    logic       v;
    logic [2:0] ml;
    logic [1:0] pl;
    logic       f;
    logic [1:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] main_light = 2'b00;
  logic [1:0] ped_light = 2'b00;
  logic       fault_clr = 1'b0;
  logic [2:0] main_lamp;
  logic [1:0] ped_lamp;
  logic       fault;
  logic [1:0] fault_code;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  localparam exp_t DC = '0;

  light_lamp_driver #(.PED_STEADY(20), .FLASH_HALF(5)) dut (
    .clk(clk), .rst_n(rst_n), .main_light(main_light), .ped_light(ped_light),
    .fault_clr(fault_clr), .main_lamp(main_lamp), .ped_lamp(ped_lamp),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] ml, input logic [1:0] pl,
                              input logic f, input logic [1:0] fc);
    exp_t e;
    e.v = 1'b1; e.ml = ml; e.pl = pl; e.f = f; e.fc = fc;
    return e;
  endfunction

  function automatic logic [2:0] dec(input logic [1:0] m);
    case (m)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] red_flash(input int j);
    return (((j / 5) % 2) == 0) ? 3'b100 : 3'b000;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, return the matured one.
  task automatic step(input logic [1:0] m, input logic [1:0] p, input logic c,
                      input exp_t ex, output exp_t got);
    @(negedge clk);
    main_light = m; ped_light = p; fault_clr = c;
    q.push_back(ex);
    @(posedge clk);
    #1;
    if (q.size() > 0) got = q.pop_front();
    else got = DC;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    main_light = 2'b00; ped_light = 2'b00; fault_clr = 1'b0;
    q.delete();
    #1;
  endtask

  // Release away from the edge; the first edge after release shows the reset samples' decode.
  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    q.push_back(mk(3'b100, 2'b10, 1'b0, 2'b00));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (main_lamp !== 3'b100) begin failures++; $display("FAIL reset_main_lamp got=%b exp=100", main_lamp); end
    checks++;
    if (ped_lamp !== 2'b10) begin failures++; $display("FAIL reset_ped_lamp got=%b exp=10", ped_lamp); end
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++;
    if (fault_code !== 2'b00) begin failures++; $display("FAIL reset_fault_code got=%b exp=00", fault_code); end
    release_reset();
  endtask

  task automatic test_main_sequence();
    logic [1:0] seq [4];
    exp_t e;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++) begin
        step(seq[k], 2'b00, 1'b0, mk(dec(seq[k]), 2'b10, 1'b0, 2'b00), e);
        if (e.v) begin
          checks++;
          if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
            failures++;
            $display("FAIL main_seq k=%0d r=%0d got=%b exp=%b", k, r,
                     {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
          end
        end
      end
    end
  endtask

  task automatic test_ped_flash();
    exp_t e;
    logic [1:0] pl;
    for (int i = 0; i < 42; i++) begin
      if (i >= 40) pl = 2'b10;
      else if (i < 20) pl = 2'b01;
      else pl = ((((i - 20) / 5) % 2) == 0) ? 2'b00 : 2'b01;
      step(2'b00, (i >= 40) ? 2'b00 : 2'b01, 1'b0, mk(3'b100, pl, 1'b0, 2'b00), e);
      if (e.v) begin
        checks++;
        if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
          failures++;
          $display("FAIL ped_flash i=%0d got=%b exp=%b", i,
                   {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
        end
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    for (int j = 0; j < 20; j++) begin
      step(2'b01, 2'b01, 1'b0, mk(red_flash(j), 2'b10, 1'b1, 2'b01), e);
      if (e.v) begin
        checks++;
        if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
          failures++;
          $display("FAIL conflict j=%0d got=%b exp=%b", j,
                   {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
        end
      end
      checks++;
      if (main_lamp[0] !== 1'b0) begin failures++; $display("FAIL conflict_no_green j=%0d got=%b exp=0", j, main_lamp[0]); end
    end
    step(2'b00, 2'b00, 1'b0, DC, e);
    step(2'b00, 2'b00, 1'b1, mk(3'b100, 2'b10, 1'b0, 2'b00), e);
    step(2'b00, 2'b00, 1'b0, mk(3'b100, 2'b10, 1'b0, 2'b00), e);
    if (e.v) begin
      checks++;
      if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
        failures++;
        $display("FAIL conflict_clear got=%b exp=%b",
                 {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
      end
    end
  endtask

  task automatic test_seq_and_clear();
    logic [1:0] m [13];
    logic [1:0] p [13];
    logic       c [13];
    exp_t       x [13];
    exp_t       e;
    for (int i = 0; i < 13; i++) begin p[i] = 2'b00; c[i] = 1'b0; end
    m[0] = 2'b01; x[0] = mk(3'b001, 2'b10, 1'b0, 2'b00);
    m[1] = 2'b01; x[1] = mk(3'b001, 2'b10, 1'b0, 2'b00);
    m[2] = 2'b00; x[2] = mk(red_flash(0), 2'b10, 1'b1, 2'b11);
    m[3] = 2'b01; x[3] = mk(red_flash(1), 2'b10, 1'b1, 2'b11);
    for (int i = 4; i < 7; i++) begin
      m[i] = 2'b01; c[i] = 1'b1; x[i] = mk(red_flash(i - 2), 2'b10, 1'b1, 2'b11);
    end
    m[7]  = 2'b00; x[7]  = DC;
    m[8]  = 2'b00; c[8] = 1'b1; x[8] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    m[9]  = 2'b01; x[9]  = mk(3'b001, 2'b10, 1'b0, 2'b00);
    m[10] = 2'b10; x[10] = mk(3'b010, 2'b10, 1'b0, 2'b00);
    m[11] = 2'b00; x[11] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    m[12] = 2'b00; x[12] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    for (int i = 0; i < 13; i++) begin
      step(m[i], p[i], c[i], x[i], e);
      if (e.v) begin
        checks++;
        if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
          failures++;
          $display("FAIL seq_clear i=%0d got=%b exp=%b", i,
                   {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [1:0] m [12];
    logic [1:0] p [12];
    logic       c [12];
    exp_t       x [12];
    exp_t       e;
    // illegal code, then a conflict that must not overwrite it
    m[0] = 2'b11; p[0] = 2'b10; c[0] = 1'b0; x[0] = mk(3'b100, 2'b10, 1'b1, 2'b10);
    m[1] = 2'b01; p[1] = 2'b01; c[1] = 1'b0; x[1] = mk(3'b100, 2'b10, 1'b1, 2'b10);
    m[2] = 2'b01; p[2] = 2'b01; c[2] = 1'b0; x[2] = DC;
    m[3] = 2'b00; p[3] = 2'b00; c[3] = 1'b0; x[3] = DC;
    m[4] = 2'b00; p[4] = 2'b00; c[4] = 1'b1; x[4] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    // illegal ped code together with 00 -> 10 sequence error
    m[5] = 2'b10; p[5] = 2'b10; c[5] = 1'b0; x[5] = mk(3'b100, 2'b10, 1'b1, 2'b10);
    m[6] = 2'b00; p[6] = 2'b00; c[6] = 1'b0; x[6] = DC;
    m[7] = 2'b00; p[7] = 2'b00; c[7] = 1'b1; x[7] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    // conflict together with 00 -> 10 sequence error
    m[8] = 2'b10; p[8] = 2'b01; c[8] = 1'b0; x[8] = mk(3'b100, 2'b10, 1'b1, 2'b01);
    m[9] = 2'b00; p[9] = 2'b00; c[9] = 1'b0; x[9] = DC;
    m[10] = 2'b00; p[10] = 2'b00; c[10] = 1'b1; x[10] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    m[11] = 2'b00; p[11] = 2'b00; c[11] = 1'b0; x[11] = mk(3'b100, 2'b10, 1'b0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      step(m[i], p[i], c[i], x[i], e);
      if (e.v) begin
        checks++;
        if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
          failures++;
          $display("FAIL priority i=%0d got=%b exp=%b", i,
                   {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [1:0] pl;
    step(2'b01, 2'b01, 1'b0, mk(3'b100, 2'b10, 1'b1, 2'b01), e);
    for (int i = 0; i < 7; i++) step(2'b01, 2'b01, 1'b0, DC, e);
    checks++;
    if (fault !== 1'b1) begin failures++; $display("FAIL mid_fault_entered got=%b exp=1", fault); end
    assert_reset();
    checks++;
    if ({main_lamp, ped_lamp, fault, fault_code} !== 8'b100_10_0_00) begin
      failures++;
      $display("FAIL reset_in_fault got=%b exp=10010000", {main_lamp, ped_lamp, fault, fault_code});
    end
    release_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 26; i++) begin
        pl = (i < 20) ? 2'b01 : 2'b00;
        step(2'b00, 2'b01, 1'b0, mk(3'b100, pl, 1'b0, 2'b00), e);
        if (e.v) begin
          checks++;
          if ({main_lamp, ped_lamp, fault, fault_code} !== {e.ml, e.pl, e.f, e.fc}) begin
            failures++;
            $display("FAIL reset_ped pass=%0d i=%0d got=%b exp=%b", pass, i,
                     {main_lamp, ped_lamp, fault, fault_code}, {e.ml, e.pl, e.f, e.fc});
          end
        end
      end
      if (pass == 0) begin
        assert_reset();
        checks++;
        if ({main_lamp, ped_lamp, fault, fault_code} !== 8'b100_10_0_00) begin
          failures++;
          $display("FAIL reset_in_flash got=%b exp=10010000", {main_lamp, ped_lamp, fault, fault_code});
        end
        release_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_sequence();
    test_ped_flash();
    test_conflict();
    test_seq_and_clear();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
